// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_mem_pkg                                                  |
// | Description : Shared constants and FSM state encoding for the memory-stage |
// |               data-memory responder.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_mem_pkg;

  // Default geometry of the data memory path
  localparam int unsigned C_ADDR_W    = 16;
  localparam int unsigned C_DATA_W    = 16;
  localparam int unsigned C_MEM_WORDS = 1024;

  // Responder FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_READ_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  // Unsigned range check done in a wide domain so any ADDR_W up to 64 works
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned words);
    return addr < 64'(words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder_if                                        |
// | Description : Request/response valid-ready bus between the memory stage    |
// |               (master) and the data-memory responder (slave).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface data_mem_responder_if
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned DATA_W = C_DATA_W
);

  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Initiator side: the pipeline memory stage
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side: this block
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                           |
// | Description : Single-outstanding load/store responder driving a 1-cycle    |
// |               registered-read synchronous RAM, with address range check.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = C_ADDR_W,
  parameter int unsigned DATA_W    = C_DATA_W,
  parameter int unsigned MEM_WORDS = C_MEM_WORDS
) (
  input  wire logic              clk,
  input  wire logic              reset,
  data_mem_responder_if.slave    bus,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_wren,
  input  wire logic [DATA_W-1:0] ram_q
);

  state_t            r_state;
  logic              r_is_store;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_wren;

  logic              w_accept;
  logic              w_in_range;
  logic              w_rsp_done;

  // Request/response handshake qualifiers
  assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
  assign w_in_range = addr_in_range(64'(bus.req_addr), MEM_WORDS);
  assign w_rsp_done = r_rsp_valid && bus.rsp_ready;

  // Sequencer: accept, drive RAM, collect read data, hold response until taken
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wren  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_in_range) begin
              // Latch the whole request; RAM sees it during ISSUE
              r_ram_addr  <= bus.req_addr;
              r_ram_wdata <= bus.req_wdata;
              r_ram_wren  <= bus.req_we;
              r_is_store  <= bus.req_we;
              r_state     <= ST_ISSUE;
            end else begin
              // Out-of-range: answer immediately, never touch the RAM
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end

        ST_ISSUE: begin
          // Write strobe lasts exactly this one cycle
          r_ram_wren <= 1'b0;
          if (r_is_store) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_state <= ST_READ_WAIT;
          end
        end

        ST_READ_WAIT: begin
          // RAM registered its read at the end of ISSUE; q is valid now
          r_rsp_rdata <= ram_q;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_ram_wren  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wren  = r_ram_wren;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                        |
// | Description : Self-checking bench for data_mem_responder with a behavioural|
// |               RAM and a word-array reference model.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;
  import cpu_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 1024;
  localparam int IW = $clog2(MW);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q)
  );

  // Behavioural single-port RAM, registered read, not reset
  logic [DW-1:0] ram [0:MW-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_addr[IW-1:0]] <= ram_wdata;
    ram_q <= ram[ram_addr[IW-1:0]];
  end

  // Reference contents of memory as the initiator sees it
  logic [DW-1:0] model [0:MW-1];

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cycles = 0;
  int exp_wren = 0;
  int cyc = 0;
  logic collect = 1'b0;
  logic [DW-1:0] rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Count write-strobe cycles mid-cycle
  always @(negedge clk) if (ram_wren === 1'b1) wren_cycles++;

  // Collect completed responses for the streaming test
  always @(negedge clk)
    if (collect && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_rdata);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction with optional response backpressure
  task automatic run_req(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int stall);
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
    int            lat;
    exp_err = (int'(addr) >= MW);
    exp_lat = exp_err ? 1 : (we ? 2 : 3);
    exp_rd  = (exp_err || we) ? '0 : model[addr[IW-1:0]];
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (stall == 0);
    @(posedge clk); #1;
    // Scramble request fields: must be ignored after the accept edge
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    if (we && !exp_err) begin
      model[addr[IW-1:0]] = wdata;
      exp_wren++;
    end
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      check("bp_err", 32'(bus.rsp_err), 32'(exp_err));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid_low", 32'(bus.rsp_valid), 32'd0);
    check("hs_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // Watch for any response over a few cycles after a reset
  task automatic expect_silence(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int acc [1:4];
    int guard;
    int r;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < MW; i++) model[i] = '0;

    // Reset values
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ram_wren", 32'(ram_wren), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store then load
    run_req(1'b1, 16'h0010, 16'hBEEF, 0);
    run_req(1'b0, 16'h0010, 16'h0000, 0);

    // Out-of-range load and the last valid word
    guard = wren_cycles;
    run_req(1'b0, 16'h0400, 16'h0000, 0);
    run_req(1'b1, 16'h0400, 16'h1234, 0);
    check("oor_no_wren", 32'(wren_cycles - guard), 32'd0);
    run_req(1'b1, 16'h03FF, 16'hA55A, 0);
    run_req(1'b0, 16'h03FF, 16'h0000, 0);
    run_req(1'b0, 16'hFFFF, 16'h0000, 1);

    // Backpressure on a load
    run_req(1'b0, 16'h0010, 16'h0000, 5);

    // Back-to-back loads with valid and ready held high
    for (int i = 1; i <= 4; i++) run_req(1'b1, AW'(i), DW'(16'h1111 * i), 0);
    rsp_q.delete();
    collect = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.req_addr = AW'(i);
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 4) bus.req_valid = 1'b0;
    end
    guard = 0;
    while (rsp_q.size() < 4 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    collect = 1'b0;
    check("b2b_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 2; i <= 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
    for (int i = 1; i <= 4; i++)
      if (rsp_q.size() >= i) check("b2b_rdata", 32'(rsp_q[i-1]), 32'(16'h1111 * i));
    @(posedge clk); #1;

    // Reset while a load waits for RAM data
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0002;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rw_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rw_rst_ready", 32'(bus.req_ready), 32'd1);
    expect_silence("rw_rst_no_rsp");
    run_req(1'b0, 16'h0003, 16'h0000, 0);

    // Reset landing on a store's write cycle still writes the RAM
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'h5A5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model[16'h0020] = 16'h5A5A;
    exp_wren++;
    check("st_rst_valid", 32'(bus.rsp_valid), 32'd0);
    expect_silence("st_rst_no_rsp");
    run_req(1'b0, 16'h0020, 16'h0000, 0);

    // Prefill a working window, then random traffic against the model
    for (int i = 0; i < 64; i++) run_req(1'b1, AW'(i), DW'($urandom), 0);
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = AW'($urandom_range(MW, 65535));
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? AW'(MW - 1) : AW'(MW);
      else             a = AW'($urandom_range(0, 63));
      run_req(1'($urandom_range(0, 1)), a, DW'($urandom), int'($urandom_range(0, 3)));
    end

    check("wren_cycles", 32'(wren_cycles), 32'(exp_wren));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
